// File: rtl/lockstep_pkg.sv
// Shared types and default sizes for the lockstep request-alignment stage.
package lockstep_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ISSUE   = 2'd2
  } state_t;

  localparam int unsigned NB_CORES_DEF = 8;
  localparam int unsigned ADDR_W_DEF   = 32;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned TIMEOUT_DEF  = 15;
  localparam int unsigned ERR_CNT_W    = 8;

endpackage

// File: rtl/lockstep_payload_cmp.sv
// Combinational equality reduction over the lanes selected by lane_mask.
// Address and write-enable always take part; with LOCKSTEP_WDATA_CHECK_EN
// defined, all-write transactions also compare write data and byte enables.
module lockstep_payload_cmp
  import lockstep_pkg::*;
#(
  parameter int unsigned NB_CORES = NB_CORES_DEF,
`ifdef LOCKSTEP_WDATA_CHECK_EN
  parameter int unsigned DATA_W   = DATA_W_DEF,
`endif
  parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
  input  logic [NB_CORES-1:0]          lane_mask,
  input  logic [NB_CORES*ADDR_W-1:0]   add,
  input  logic [NB_CORES-1:0]          wen,
`ifdef LOCKSTEP_WDATA_CHECK_EN
  input  logic [NB_CORES*DATA_W-1:0]   wdata,
  input  logic [NB_CORES*DATA_W/8-1:0] be,
`endif
  output logic                         eq
);

`ifdef LOCKSTEP_WDATA_CHECK_EN
  localparam int unsigned BE_W = DATA_W / 8;

  logic [DATA_W-1:0] ref_wdata;
  logic [BE_W-1:0]   ref_be;
`endif
  logic              have_ref;
  logic [ADDR_W-1:0] ref_add;
  logic              ref_wen;

  // The first selected lane is the reference; every later selected lane must match it
  always_comb begin
    eq        = 1'b1;
    have_ref  = 1'b0;
    ref_add   = '0;
    ref_wen   = 1'b0;
`ifdef LOCKSTEP_WDATA_CHECK_EN
    ref_wdata = '0;
    ref_be    = '0;
`endif
    for (int i = 0; i < NB_CORES; i++) begin
      if (lane_mask[i]) begin
        if (!have_ref) begin
          have_ref  = 1'b1;
          ref_add   = add[i*ADDR_W +: ADDR_W];
          ref_wen   = wen[i];
`ifdef LOCKSTEP_WDATA_CHECK_EN
          ref_wdata = wdata[i*DATA_W +: DATA_W];
          ref_be    = be[i*BE_W +: BE_W];
`endif
        end else begin
          if ((add[i*ADDR_W +: ADDR_W] != ref_add) || (wen[i] != ref_wen)) begin
            eq = 1'b0;
          end
`ifdef LOCKSTEP_WDATA_CHECK_EN
          // A read/write mix already fails above, so two writes here mean an all-write set
          if (!wen[i] && !ref_wen &&
              ((wdata[i*DATA_W +: DATA_W] != ref_wdata) || (be[i*BE_W +: BE_W] != ref_be))) begin
            eq = 1'b0;
          end
`endif
        end
      end
    end
  end

endmodule

// File: rtl/lockstep_req_sync.sv
// Lockstep request-alignment stage in front of the grant/rvalid combiner.
// Holds masked core requests until all have arrived (or a timeout forces
// issue), compares payloads and issues the aligned set with a registered
// same_address flag. Transparent when lockstep is off or the mask is empty.
// Optional macro: LOCKSTEP_WDATA_CHECK_EN adds wdata/be to the comparison.
module lockstep_req_sync
  import lockstep_pkg::*;
#(
  parameter int unsigned NB_CORES = NB_CORES_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         lockstep_mode_i,
  input  logic [NB_CORES-1:0]          core_mask_i,
  input  logic [NB_CORES-1:0]          core_req_i,
  input  logic [NB_CORES*ADDR_W-1:0]   core_add_i,
  input  logic [NB_CORES-1:0]          core_wen_i,
  input  logic [NB_CORES*DATA_W-1:0]   core_wdata_i,
  input  logic [NB_CORES*DATA_W/8-1:0] core_be_i,
  output logic [NB_CORES-1:0]          core_gnt_o,
  output logic [NB_CORES-1:0]          out_req_o,
  output logic [NB_CORES*ADDR_W-1:0]   out_add_o,
  output logic [NB_CORES-1:0]          out_wen_o,
  output logic [NB_CORES*DATA_W-1:0]   out_wdata_o,
  output logic [NB_CORES*DATA_W/8-1:0] out_be_o,
  input  logic [NB_CORES-1:0]          out_gnt_i,
  output logic                         same_address_o,
  output logic                         mismatch_o,
  output logic                         timeout_o,
  output logic [ERR_CNT_W-1:0]         err_cnt_o
);

  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

  state_t state_q, state_d;

  logic [NB_CORES-1:0]        pending_q, pending_nx;
  logic [NB_CORES-1:0]        issue_mask_q;
  logic [NB_CORES-1:0]        mask_q;
  logic [NB_CORES*ADDR_W-1:0] cap_add_q, cap_add_nx;
  logic [NB_CORES-1:0]        cap_wen_q, cap_wen_nx;
  logic [NB_CORES*DATA_W-1:0] cap_wdata_q, cap_wdata_nx;
  logic [NB_CORES*BE_W-1:0]   cap_be_q, cap_be_nx;
  logic [TCNT_W-1:0]          tcnt_q;
  logic                       same_addr_q;
  logic                       mismatch_q;
  logic                       timeout_q;
  logic [ERR_CNT_W-1:0]       err_cnt_q, err_cnt_nx;
  logic [ERR_CNT_W:0]         err_sum;
  logic [1:0]                 err_inc;

  logic                       lockstep_on;
  logic                       bypass;
  logic                       capturing;
  logic [NB_CORES-1:0]        eff_mask;
  logic [NB_CORES-1:0]        masked_req;
  logic                       all_granted;
  logic                       cmp_eq;
  logic                       go_issue, go_collect, go_idle, forced;

  // Mode and mask only matter in IDLE; once a transaction starts the latched mask rules
  assign lockstep_on = lockstep_mode_i && (core_mask_i != '0);
  assign bypass      = rst_ni && (state_q == IDLE) && !lockstep_on;
  assign capturing   = ((state_q == IDLE) && lockstep_on) || (state_q == COLLECT);
  assign eff_mask    = (state_q == IDLE) ? core_mask_i : mask_q;
  assign masked_req  = core_req_i & eff_mask;
  assign all_granted = ((out_gnt_i & issue_mask_q) == issue_mask_q);

  // Saturating error counter: a transaction adds one per mismatch and one per timeout
  assign err_inc    = {1'b0, !cmp_eq} + {1'b0, forced};
  assign err_sum    = {1'b0, err_cnt_q} + {{(ERR_CNT_W-1){1'b0}}, err_inc};
  assign err_cnt_nx = err_sum[ERR_CNT_W] ? {ERR_CNT_W{1'b1}} : err_sum[ERR_CNT_W-1:0];

  // Accumulate pending bits and snapshot each lane's payload on its first arrival
  always_comb begin
    pending_nx   = pending_q;
    cap_add_nx   = cap_add_q;
    cap_wen_nx   = cap_wen_q;
    cap_wdata_nx = cap_wdata_q;
    cap_be_nx    = cap_be_q;
    if (capturing) begin
      pending_nx = pending_q | masked_req;
      for (int i = 0; i < NB_CORES; i++) begin
        if (masked_req[i] && !pending_q[i]) begin
          cap_add_nx[i*ADDR_W +: ADDR_W]   = core_add_i[i*ADDR_W +: ADDR_W];
          cap_wen_nx[i]                    = core_wen_i[i];
          cap_wdata_nx[i*DATA_W +: DATA_W] = core_wdata_i[i*DATA_W +: DATA_W];
          cap_be_nx[i*BE_W +: BE_W]        = core_be_i[i*BE_W +: BE_W];
        end
      end
    end
  end

  // Compare the payload set that will be issued, including lanes captured this cycle
  lockstep_payload_cmp #(
    .NB_CORES (NB_CORES),
`ifdef LOCKSTEP_WDATA_CHECK_EN
    .DATA_W   (DATA_W),
`endif
    .ADDR_W   (ADDR_W)
  ) u_cmp (
    .lane_mask (pending_nx),
    .add       (cap_add_nx),
    .wen       (cap_wen_nx),
`ifdef LOCKSTEP_WDATA_CHECK_EN
    .wdata     (cap_wdata_nx),
    .be        (cap_be_nx),
`endif
    .eq        (cmp_eq)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; completion is checked before the timeout so it wins a tie
  always_comb begin
    state_d    = state_q;
    go_issue   = 1'b0;
    go_collect = 1'b0;
    go_idle    = 1'b0;
    forced     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (lockstep_on && (masked_req != '0)) begin
          if (pending_nx == core_mask_i) go_issue   = 1'b1;
          else                           go_collect = 1'b1;
        end
      end
      COLLECT: begin
        if (pending_nx == mask_q) begin
          go_issue = 1'b1;
        end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
          go_issue = 1'b1;
          forced   = 1'b1;
        end
      end
      ISSUE: begin
        if (all_granted) go_idle = 1'b1;
      end
      default: go_idle = 1'b1;
    endcase
    if (go_issue)        state_d = ISSUE;
    else if (go_collect) state_d = COLLECT;
    else if (go_idle)    state_d = IDLE;
  end

  // Datapath registers: capture, timeout counter, issue snapshot and event pulses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q    <= '0;
      issue_mask_q <= '0;
      mask_q       <= '0;
      cap_add_q    <= '0;
      cap_wen_q    <= '0;
      cap_wdata_q  <= '0;
      cap_be_q     <= '0;
      tcnt_q       <= '0;
      same_addr_q  <= 1'b0;
      mismatch_q   <= 1'b0;
      timeout_q    <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      mismatch_q  <= 1'b0;
      timeout_q   <= 1'b0;
      pending_q   <= pending_nx;
      cap_add_q   <= cap_add_nx;
      cap_wen_q   <= cap_wen_nx;
      cap_wdata_q <= cap_wdata_nx;
      cap_be_q    <= cap_be_nx;
      if (state_q == IDLE) mask_q <= core_mask_i;
      if (go_collect) begin
        tcnt_q <= '0;
      end else if (state_q == COLLECT) begin
        tcnt_q <= tcnt_q + 1'b1;
      end
      if (go_issue) begin
        issue_mask_q <= pending_nx;
        same_addr_q  <= cmp_eq && (pending_nx == eff_mask) && !forced;
        mismatch_q   <= !cmp_eq;
        timeout_q    <= forced;
        err_cnt_q    <= err_cnt_nx;
      end
      if (go_idle) begin
        pending_q    <= '0;
        issue_mask_q <= '0;
        same_addr_q  <= 1'b0;
      end
    end
  end

  // Outputs: straight wires in bypass, otherwise the captured set gated by ISSUE
  always_comb begin
    if (bypass) begin
      out_req_o      = core_req_i;
      out_add_o      = core_add_i;
      out_wen_o      = core_wen_i;
      out_wdata_o    = core_wdata_i;
      out_be_o       = core_be_i;
      core_gnt_o     = out_gnt_i;
      same_address_o = 1'b0;
    end else begin
      out_req_o      = (state_q == ISSUE) ? issue_mask_q : '0;
      out_add_o      = cap_add_q;
      out_wen_o      = cap_wen_q;
      out_wdata_o    = cap_wdata_q;
      out_be_o       = cap_be_q;
      core_gnt_o     = (state_q == ISSUE) ? (out_gnt_i & issue_mask_q) : '0;
      same_address_o = (state_q == ISSUE) && same_addr_q;
    end
    mismatch_o = mismatch_q;
    timeout_o  = timeout_q;
    err_cnt_o  = err_cnt_q;
  end

endmodule

// File: tb/tb_lockstep_req_sync.sv
// Bench for lockstep_req_sync: directed scenarios plus randomized
// transactions against a transaction-level reference model.
module tb_lockstep_req_sync;

  localparam int NB = 8;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             lockstep_mode_i;
  logic [NB-1:0]    core_mask_i;
  logic [NB-1:0]    core_req_i;
  logic [NB*AW-1:0] core_add_i;
  logic [NB-1:0]    core_wen_i;
  logic [NB*DW-1:0] core_wdata_i;
  logic [NB*BW-1:0] core_be_i;
  logic [NB-1:0]    core_gnt_o;
  logic [NB-1:0]    out_req_o;
  logic [NB*AW-1:0] out_add_o;
  logic [NB-1:0]    out_wen_o;
  logic [NB*DW-1:0] out_wdata_o;
  logic [NB*BW-1:0] out_be_o;
  logic [NB-1:0]    out_gnt_i;
  logic             same_address_o;
  logic             mismatch_o;
  logic             timeout_o;
  logic [7:0]       err_cnt_o;

  int compared   = 0;
  int mismatched = 0;
  int exp_err;

  int          arr[NB];
  logic [31:0] lane_add[NB];
  logic        lane_wen[NB];
  logic [31:0] lane_wdata[NB];
  logic [3:0]  lane_be[NB];
  int          gnt_dly;

  lockstep_req_sync dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .lockstep_mode_i (lockstep_mode_i),
    .core_mask_i     (core_mask_i),
    .core_req_i      (core_req_i),
    .core_add_i      (core_add_i),
    .core_wen_i      (core_wen_i),
    .core_wdata_i    (core_wdata_i),
    .core_be_i       (core_be_i),
    .core_gnt_o      (core_gnt_o),
    .out_req_o       (out_req_o),
    .out_add_o       (out_add_o),
    .out_wen_o       (out_wen_o),
    .out_wdata_o     (out_wdata_o),
    .out_be_o        (out_be_o),
    .out_gnt_i       (out_gnt_i),
    .same_address_o  (same_address_o),
    .mismatch_o      (mismatch_o),
    .timeout_o       (timeout_o),
    .err_cnt_o       (err_cnt_o)
  );

  // Free-running clock, period 10
  always #5 clk_i = ~clk_i;

  // Hard stop if the sequence ever wedges
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setUniform(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] b);
    for (int i = 0; i < NB; i++) begin
      arr[i]        = 0;
      lane_add[i]   = a;
      lane_wen[i]   = w;
      lane_wdata[i] = d;
      lane_be[i]    = b;
    end
    gnt_dly = 0;
  endtask

  // One lockstep transaction: predict the outcome from the arrival schedule, then drive and check
  task automatic applyStimulus(input string tag);
    int           m, issue_cyc, first;
    logic [7:0]   incl, exp_wen, noise;
    logic         eq, to, all_wr, exp_same, done;
    logic [255:0] exp_add, add_keep, exp_wd, wd_keep;
    logic [31:0]  exp_be, be_keep;
    m = 0;
    for (int i = 0; i < NB; i++) if (core_mask_i[i] && arr[i] > m) m = arr[i];
    to        = (m > 15);
    issue_cyc = to ? 16 : m + 1;
    incl      = '0;
    for (int i = 0; i < NB; i++) if (core_mask_i[i] && arr[i] <= 15) incl[i] = 1'b1;
    eq = 1'b1; all_wr = 1'b1; first = -1;
    exp_add = '0; add_keep = '0; exp_wd = '0; wd_keep = '0; exp_be = '0; be_keep = '0; exp_wen = '0;
    for (int i = 0; i < NB; i++) begin
      if (incl[i]) begin
        exp_add[i*32 +: 32] = lane_add[i];   add_keep[i*32 +: 32] = '1;
        exp_wd[i*32 +: 32]  = lane_wdata[i]; wd_keep[i*32 +: 32]  = '1;
        exp_be[i*4 +: 4]    = lane_be[i];    be_keep[i*4 +: 4]    = '1;
        exp_wen[i]          = lane_wen[i];
        if (lane_wen[i]) all_wr = 1'b0;
        if (first < 0) first = i;
        else if (lane_add[i] != lane_add[first] || lane_wen[i] != lane_wen[first]) eq = 1'b0;
      end
    end
`ifdef LOCKSTEP_WDATA_CHECK_EN
    if (all_wr) begin
      for (int i = 0; i < NB; i++)
        if (incl[i] && (lane_wdata[i] != lane_wdata[first] || lane_be[i] != lane_be[first])) eq = 1'b0;
    end
`endif
    exp_same = eq && (incl == core_mask_i) && !to;
    if (!eq) exp_err++;
    if (to)  exp_err++;
    if (exp_err > 255) exp_err = 255;

    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      noise = 8'($urandom);
      for (int i = 0; i < NB; i++) begin
        core_req_i[i] = core_mask_i[i] ? (arr[i] == c) : noise[i];
        if (core_mask_i[i] && arr[i] == c) begin
          core_add_i[i*AW +: AW]   = lane_add[i];
          core_wen_i[i]            = lane_wen[i];
          core_wdata_i[i*DW +: DW] = lane_wdata[i];
          core_be_i[i*BW +: BW]    = lane_be[i];
        end else begin
          core_add_i[i*AW +: AW]   = $urandom;
          core_wen_i[i]            = 1'($urandom);
          core_wdata_i[i*DW +: DW] = $urandom;
          core_be_i[i*BW +: BW]    = 4'($urandom);
        end
      end
      out_gnt_i = (c >= issue_cyc + gnt_dly) ? (incl | (noise & ~incl)) : (noise & ~incl);
      @(negedge clk_i);
      if (c < issue_cyc) begin
        checkOutput({tag, " wait_req_gnt"}, {out_req_o, core_gnt_o}, 16'h0);
      end else begin
        checkOutput({tag, " out_req"}, out_req_o, incl);
        checkOutput({tag, " same_address"}, same_address_o, exp_same);
        if (c == issue_cyc) begin
          checkOutput({tag, " mismatch"}, mismatch_o, !eq);
          checkOutput({tag, " timeout"}, timeout_o, to);
          checkOutput({tag, " err_cnt"}, err_cnt_o, exp_err[7:0]);
          checkOutput({tag, " out_add"}, out_add_o & add_keep, exp_add);
          checkOutput({tag, " out_wen"}, out_wen_o & incl, exp_wen);
          checkOutput({tag, " out_wdata"}, out_wdata_o & wd_keep, exp_wd);
          checkOutput({tag, " out_be"}, out_be_o & be_keep, exp_be);
        end else begin
          checkOutput({tag, " pulse_once"}, {mismatch_o, timeout_o}, 2'b00);
        end
        if (c == issue_cyc + gnt_dly) begin
          checkOutput({tag, " core_gnt"}, core_gnt_o, incl);
          done = 1'b1;
        end else begin
          checkOutput({tag, " gnt_held"}, core_gnt_o, 8'h00);
        end
      end
      @(posedge clk_i); #1;
    end
    checkOutput({tag, " completed"}, done, 1'b1);
    core_req_i = '0;
    out_gnt_i  = '0;
  endtask

  initial begin
    rst_ni = 1'b0; lockstep_mode_i = 1'b1; core_mask_i = 8'hFF; core_req_i = '0;
    core_add_i = '0; core_wen_i = '0; core_wdata_i = '0; core_be_i = '0; out_gnt_i = '0;
    exp_err = 0;
    #2;
    checkOutput("reset_outputs", {out_req_o, core_gnt_o, same_address_o, mismatch_o, timeout_o, err_cnt_o}, 27'h0);
    checkOutput("reset_payload", out_add_o, '0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Bypass: mode off, core 3 request passes straight through
    lockstep_mode_i = 1'b0;
    core_req_i = 8'h08; core_add_i[3*AW +: AW] = 32'h100; out_gnt_i = 8'h08;
    @(negedge clk_i);
    checkOutput("bypass_req", out_req_o, 8'h08);
    checkOutput("bypass_add", out_add_o[3*AW +: AW], 32'h100);
    checkOutput("bypass_gnt", core_gnt_o, 8'h08);
    checkOutput("bypass_same", same_address_o, 1'b0);
    @(posedge clk_i); #1;
    lockstep_mode_i = 1'b1; core_mask_i = 8'h00; core_req_i = 8'h21; out_gnt_i = 8'h20;
    @(negedge clk_i);
    checkOutput("bypass_nomask", {out_req_o, core_gnt_o}, 16'h2120);
    @(posedge clk_i); #1;
    core_req_i = '0; out_gnt_i = '0; core_mask_i = 8'hFF;
    @(posedge clk_i); #1;

    setUniform(32'h1000, 1'b1, 32'h0, 4'hF);
    applyStimulus("aligned");

    setUniform(32'h2000, 1'b1, 32'h0, 4'hF);
    for (int i = 4; i < 8; i++) arr[i] = 3;
    applyStimulus("skewed");

    setUniform(32'h2000, 1'b1, 32'h0, 4'hF);
    arr[7] = 15; gnt_dly = 2;
    applyStimulus("late_complete");

    setUniform(32'h2000, 1'b1, 32'h0, 4'hF);
    lane_add[5] = 32'h2004;
    applyStimulus("mismatch");

    setUniform(32'h2000, 1'b1, 32'h0, 4'hF);
    arr[7] = 99; gnt_dly = 1;
    applyStimulus("timeout");

    setUniform(32'h40, 1'b0, 32'hBEEF, 4'hF);
    lane_wdata[2] = 32'hDEAD;
    applyStimulus("write_data");

    for (int t = 0; t < 40; t++) begin
      int fl;
      core_mask_i = 8'($urandom_range(1, 255));
      setUniform($urandom & 32'hFFFF_FFFC, 1'($urandom), $urandom, 4'($urandom));
      gnt_dly = $urandom_range(0, 3);
      fl = -1;
      for (int i = 0; i < NB; i++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 4)       arr[i] = 0;
        else if (r < 8)  arr[i] = $urandom_range(1, 14);
        else if (r == 8) arr[i] = 15;
        else             arr[i] = 99;
        if ($urandom_range(0, 9) == 0)  lane_add[i] = lane_add[i] ^ 32'h4;
        if ($urandom_range(0, 15) == 0) lane_wen[i] = !lane_wen[i];
        if ($urandom_range(0, 7) == 0)  lane_wdata[i] = $urandom;
        if (core_mask_i[i] && fl < 0) fl = i;
      end
      arr[fl] = 0;
      applyStimulus("random");
    end

    core_mask_i = 8'hFF;
    for (int t = 0; t < 260; t++) begin
      setUniform(32'h3000, 1'b1, 32'h0, 4'hF);
      lane_add[t % NB] = 32'h3008;
      applyStimulus("saturate");
    end
    checkOutput("err_saturated", err_cnt_o, 8'd255);

    // Reset asserted while a transaction sits in ISSUE waiting for its grant
    for (int i = 0; i < NB; i++) begin
      core_add_i[i*AW +: AW] = 32'h5000;
      core_wen_i[i] = 1'b1;
    end
    core_req_i = 8'hFF;
    @(posedge clk_i); #1;
    core_req_i = '0;
    @(negedge clk_i);
    checkOutput("issue_before_reset", out_req_o, 8'hFF);
    #1 rst_ni = 1'b0;
    #1;
    checkOutput("reset_in_issue", {out_req_o, core_gnt_o, same_address_o, mismatch_o, timeout_o, err_cnt_o}, 27'h0);
    checkOutput("reset_in_issue_payload", {out_add_o, out_wen_o}, '0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    exp_err = 0;
    setUniform(32'h6000, 1'b1, 32'h0, 4'hF);
    applyStimulus("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
